prio_drain_encoder: RTL and testbench

PRIO_DRAIN_ENCODER -- requirements
Module: prio_drain_encoder

---
 rtl/prio_drain_pkg.sv | 13 +
 rtl/prio_find_msb.sv | 25 ++
 rtl/prio_drain_encoder.sv | 83 ++++++++
 tb/tb_prio_drain_encoder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/prio_drain_pkg.sv
// Shared types and helpers for the priority drain encoder.
package prio_drain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  function automatic int idx_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/prio_find_msb.sv
// Combinational highest-set-bit finder; idx is 0 when no bit is set.
module prio_find_msb
  import prio_drain_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Ascending scan: the highest set bit is the last one written.
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_drain_encoder.sv
// Drains a request vector into one index beat per set bit, highest first.
// Optional out_remain popcount port is enabled by defining PRIO_DRAIN_COUNT_EN.
module prio_drain_encoder
  import prio_drain_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int IDX_W = idx_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
`ifdef PRIO_DRAIN_COUNT_EN
  ,
  output logic [IDX_W:0]   out_remain
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] mask;
  logic [IDX_W-1:0] msb_idx;
  logic             msb_any;
  logic [WIDTH-1:0] rest;
  logic             drain;
  logic             last;
  logic             accept;
  logic             retire;

  prio_find_msb #(.WIDTH(WIDTH)) u_find (
    .vec (mask),
    .idx (msb_idx),
    .any (msb_any)
  );

  // Outputs are forced idle while rst is high so nothing can hand off during reset.
  assign drain  = (state == DRAIN) && !rst;
  assign rest   = mask & ~(ONE << msb_idx);
  assign last   = (rest == '0);
  assign retire = drain && out_ready;
  assign accept = in_valid && in_ready;

  assign in_ready  = !rst && ((state == IDLE) || (drain && last && out_ready));
  assign out_valid = drain;
  assign out_idx   = drain ? msb_idx : '0;
  assign out_last  = drain && last;
  assign out_zero  = drain && !msb_any;

`ifdef PRIO_DRAIN_COUNT_EN
  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + (IDX_W+1)'(v[i]);
    return n;
  endfunction

  assign out_remain = drain ? popcount(mask) : '0;
`endif

  // A new vector accepted on the final retire overrides the cleared mask: no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mask  <= '0;
    end else begin
      if (retire) mask <= rest;
      if (accept) begin
        mask  <= in_data;
        state <= DRAIN;
      end else if (retire && last) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_prio_drain_encoder.sv
// Directed scoreboard bench for prio_drain_encoder at WIDTH=8.
module tb_prio_drain_encoder;

  localparam int WIDTH = 8;
  localparam int IDX_W = 3;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             last;
    logic             zero;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;
  logic             out_zero;
`ifdef PRIO_DRAIN_COUNT_EN
  logic [IDX_W:0]   out_remain;
`endif

  int    tests = 0;
  int    fails = 0;
  beat_t sb[$];

  prio_drain_encoder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_zero  (out_zero)
`ifdef PRIO_DRAIN_COUNT_EN
    ,
    .out_remain(out_remain)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic last, input logic zero);
    beat_t b;
    b.idx  = IDX_W'(idx);
    b.last = last;
    b.zero = zero;
    sb.push_back(b);
  endtask

  // Every completed handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beat_t e;
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_beat: observed idx %0d expected no beat", out_idx);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("beat_idx", out_idx, e.idx);
        check("beat_last", out_last, e.last);
        check("beat_zero", out_zero, e.zero);
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_zero", out_zero, 0);
`ifdef PRIO_DRAIN_COUNT_EN
    check("rst_remain", out_remain, 0);
`endif
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    step();

    // 1010_0100 drains 7,5,2 on consecutive cycles
    in_valid = 1'b1; in_data = 8'b1010_0100; out_ready = 1'b1;
    push(7, 0, 0); push(5, 0, 0); push(2, 1, 0);
    check("a4_in_ready", in_ready, 1);
    step(); in_valid = 1'b0; #1;
    check("a4_v0", out_valid, 1); check("a4_i0", out_idx, 7);
    step();
    check("a4_v1", out_valid, 1); check("a4_i1", out_idx, 5);
    step();
    check("a4_v2", out_valid, 1); check("a4_i2", out_idx, 2); check("a4_last2", out_last, 1);
    step();
    check("a4_idle", out_valid, 0);

    // all-zero vector: one zero beat, then idle
    in_valid = 1'b1; in_data = 8'h00; push(0, 1, 1);
    step(); in_valid = 1'b0; #1;
    check("z_valid", out_valid, 1); check("z_zero", out_zero, 1);
    check("z_idx", out_idx, 0); check("z_last", out_last, 1);
    step();
    check("z_idle", out_valid, 0); check("z_in_ready", in_ready, 1);

    // stall holds beat; a different vector offered meanwhile is ignored
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'b0001_0010;
    push(4, 0, 0); push(1, 1, 0);
    step(); in_data = 8'hFF; #1;
    for (int c = 0; c < 3; c++) begin
      check("stall_idx", out_idx, 4);
      check("stall_last", out_last, 0);
      check("stall_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1; #1;
    check("st_i0", out_idx, 4);
    step();
    check("st_i1", out_idx, 1); check("st_last", out_last, 1); check("st_in_ready", in_ready, 1);
    step();
    check("st_idle", out_valid, 0);

    // back-to-back 01 then 80 with no bubble
    in_valid = 1'b1; in_data = 8'h01; push(0, 1, 0);
    step(); in_data = 8'h80; push(7, 1, 0); #1;
    check("b2b_i0", out_idx, 0); check("b2b_in_ready", in_ready, 1);
    step(); in_valid = 1'b0; #1;
    check("b2b_v1", out_valid, 1); check("b2b_i1", out_idx, 7);
    step();
    check("b2b_idle", out_valid, 0);

    // reset mid-drain discards the remaining beats
    in_valid = 1'b1; in_data = 8'hFF; push(7, 0, 0); push(6, 0, 0); push(5, 0, 0);
    step(); in_valid = 1'b0;
    step(); step(); step();
    check("ff_pre_rst_idx", out_idx, 4);
    rst = 1'b1; #1;
    check("rst_mid_valid", out_valid, 0); check("rst_mid_in_ready", in_ready, 0);
    step(); rst = 1'b0; #1;
    check("rst_after_valid", out_valid, 0); check("rst_after_in_ready", in_ready, 1);
    check("rst_sb_empty", sb.size(), 0);
    in_valid = 1'b1; in_data = 8'h02; push(1, 1, 0);
    step(); in_valid = 1'b0; #1;
    check("r02_valid", out_valid, 1); check("r02_idx", out_idx, 1); check("r02_last", out_last, 1);
    step();
    check("r02_idle", out_valid, 0);

`ifdef PRIO_DRAIN_COUNT_EN
    in_valid = 1'b1; in_data = 8'b0110_0001; push(6, 0, 0); push(5, 0, 0); push(0, 1, 0);
    step(); in_valid = 1'b0; #1;
    check("rem0", out_remain, 3);
    step(); check("rem1", out_remain, 2);
    step(); check("rem2", out_remain, 1);
    step(); check("rem_idle", out_remain, 0);
`endif

    step();
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
